// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - Sysbus shared constants, tag layout and responder state encoding
package sysbus_pkg;

  localparam int TAG_W      = 13;
  localparam int LINE_BYTES = 64;
  localparam int LINE_BEATS = 8;

  localparam logic       DIR_READ    = 1'b1;
  localparam logic       DIR_WRITE   = 1'b0;
  localparam logic [3:0] TYPE_MEMORY = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_WDATA,
    ST_LATENCY,
    ST_RESP,
    ST_WRESP
  } resp_state_e;

  function automatic logic tag_dir(input logic [TAG_W-1:0] tag);
    return tag[TAG_W-1];
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// rtl/sysbus_mem_responder_if.sv - Sysbus request/response signal bundle
interface sysbus_mem_responder_if;
  import sysbus_pkg::*;

  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic [TAG_W-1:0] resptag;
  logic             respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );

endinterface

// File: rtl/sysbus_mem_array.sv
// rtl/sysbus_mem_array.sv - 64-bit word backing store, async read, sync write
module sysbus_mem_array #(
  parameter int unsigned MEM_BYTES = 1 << 20,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic [63:0] raddr,
  output logic [63:0] rdata,
  input  logic        we,
  input  logic [63:0] waddr,
  input  logic [63:0] wdata
);

  localparam int WORDS = int'(MEM_BYTES / 8);
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [63:0] mem [WORDS];
  logic        rd_in_range;
  logic        wr_in_range;
  logic        unused_low_bits;

  // Out-of-range beats read as zero and writes vanish; the handshake never sees it.
  assign rd_in_range     = raddr < 64'(MEM_BYTES);
  assign wr_in_range     = waddr < 64'(MEM_BYTES);
  assign rdata           = rd_in_range ? mem[raddr[AW+2:3]] : 64'h0;
  assign unused_low_bits = ^{raddr[2:0], waddr[2:0]};

  always_ff @(posedge clk) begin
    if (we && wr_in_range) begin
      mem[waddr[AW+2:3]] <= wdata;
    end
  end

endmodule

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - Sysbus memory-side responder: line reads and 8-beat line writes
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1 << 20,
  parameter int unsigned LAT       = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   reset,
  sysbus_mem_responder_if.slave  bus
);

  localparam int          LW        = (LAT == 0) ? 1 : $clog2(LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = (LAT == 0) ? '0 : LW'(LAT - 1);
  localparam logic [2:0]  LAST_BEAT = 3'(LINE_BEATS - 1);

  resp_state_e      state;
  logic [2:0]       beat;
  logic [LW-1:0]    lat_cnt;
  logic [57:0]      line_hi;
  logic [TAG_W-1:0] tag;
  logic             ack_q;
  logic             respcyc_q;
  logic [63:0]      beat_addr;
  logic [63:0]      rdata;
  logic             wdata_fire;

  assign beat_addr  = {line_hi, beat, 3'b000};
  assign wdata_fire = (state == ST_WDATA) && bus.reqcyc;

  // Data beats are acked in the same cycle they are offered; the address beat is acked registered.
  assign bus.reqack  = ack_q | wdata_fire;
  assign bus.respcyc = respcyc_q;
  assign bus.resp    = (state == ST_RESP) ? rdata : 64'h0;
  assign bus.resptag = tag;

  sysbus_mem_array #(
    .MEM_BYTES (MEM_BYTES),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .raddr (beat_addr),
    .rdata (rdata),
    .we    (wdata_fire),
    .waddr (beat_addr),
    .wdata (bus.req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      beat      <= 3'd0;
      lat_cnt   <= '0;
      line_hi   <= '0;
      tag       <= '0;
      ack_q     <= 1'b0;
      respcyc_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.reqcyc) begin
            line_hi <= bus.req[63:6];
            tag     <= bus.reqtag;
            ack_q   <= 1'b1;
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          beat    <= 3'd0;
          lat_cnt <= '0;
          if (tag_dir(tag) == DIR_WRITE) begin
            state <= ST_WDATA;
          end else if (LAT == 0) begin
            state     <= ST_RESP;
            respcyc_q <= 1'b1;
          end else begin
            state <= ST_LATENCY;
          end
        end
        ST_LATENCY: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt   <= '0;
            state     <= ST_RESP;
            respcyc_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_WDATA: begin
          if (bus.reqcyc) begin
            beat <= beat + 3'd1;
            if (beat == LAST_BEAT) begin
              state     <= ST_WRESP;
              respcyc_q <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (bus.respack) begin
            beat <= beat + 3'd1;
            if (beat == LAST_BEAT) begin
              state     <= ST_IDLE;
              respcyc_q <= 1'b0;
            end
          end
        end
        ST_WRESP: begin
          if (bus.respack) begin
            state     <= ST_IDLE;
            respcyc_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          respcyc_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - directed bench with a line-level memory model and response scoreboard
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam logic [63:0] MEM_B = 64'h100000;

  typedef struct packed {
    logic [63:0]      d;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  sysbus_mem_responder_if bus ();
  sysbus_mem_responder_if bus0 ();

  sysbus_mem_responder #(.MEM_BYTES(32'h100000), .LAT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  sysbus_mem_responder #(.MEM_BYTES(4096), .LAT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  logic [63:0] mem_m [longint unsigned];
  exp_t        exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every consumed beat must match the oldest outstanding model beat; stalled beats must hold.
  initial begin
    logic             prev_hold;
    logic [63:0]      prev_resp;
    logic [TAG_W-1:0] prev_tag;
    exp_t             e;
    prev_hold = 1'b0;
    prev_resp = '0;
    prev_tag  = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_respcyc", bus.respcyc, 1);
          chk("hold_resp", bus.resp, prev_resp);
          chk("hold_tag", bus.resptag, prev_tag);
        end
        if (bus.respcyc) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: respcyc=1 resp=%h with no beat outstanding (cycle %0d)", bus.resp, cyc);
          end else if (bus.respack) begin
            e = exp_q.pop_front();
            chk("resp_data", bus.resp, e.d);
            chk("resp_tag", bus.resptag, e.t);
          end
        end
        prev_hold = bus.respcyc && !bus.respack;
        prev_resp = bus.resp;
        prev_tag  = bus.resptag;
      end
    end
  end

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.reqack) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("reqack_seen", got, 1);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [TAG_W-1:0] tag, input logic [63:0] base);
    logic [63:0] la;
    logic [63:0] a;
    exp_t        e;
    bit          got;
    int          acks;
    bit          seen;
    la = addr & ~64'h3F;
    for (int i = 0; i < 8; i++) begin
      a = la + 64'(8 * i);
      if (a < MEM_B) mem_m[a] = base + 64'(i);
    end
    e.d = 64'h0;
    e.t = tag;
    exp_q.push_back(e);
    bus.reqcyc  = 1'b1;
    bus.req     = addr;
    bus.reqtag  = tag;
    bus.respack = 1'b1;
    wait_ack(got);
    acks = 0;
    for (int k = 0; k < 40 && acks < 8; k++) begin
      @(posedge clk);
      #1;
      bus.req = base + 64'(acks);
      @(negedge clk);
      if (bus.reqack) acks++;
    end
    chk("write_acks", acks, 8);
    @(posedge clk);
    #1;
    bus.reqcyc = 1'b0;
    bus.req    = '0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.respcyc) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("wresp_seen", seen, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wresp_drop", bus.respcyc, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [TAG_W-1:0] tag, input int lat,
                         input int stall_beat, input int stall_n, input int abort_beat,
                         input bit overlap, output logic [63:0] d0);
    logic [63:0] la;
    logic [63:0] a;
    exp_t        e;
    bit          got;
    int          t;
    int          beats;
    int          first;
    int          last;
    int          st;
    la = addr & ~64'h3F;
    for (int i = 0; i < 8; i++) begin
      a   = la + 64'(8 * i);
      e.d = (a < MEM_B && mem_m.exists(a)) ? mem_m[a] : 64'h0;
      e.t = tag;
      exp_q.push_back(e);
    end
    d0          = 'x;
    bus.reqcyc  = 1'b1;
    bus.req     = addr;
    bus.reqtag  = tag;
    bus.respack = 1'b1;
    wait_ack(got);
    t     = cyc - 1;
    beats = 0;
    first = -1;
    last  = -1;
    st    = stall_n;
    for (int k = 0; k < 200 && beats < 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) bus.reqcyc = overlap;
      if (beats == abort_beat) begin
        reset = 1'b0;
        #1;
        chk("abort_respcyc", bus.respcyc, 0);
        chk("abort_resp", bus.resp, 0);
        exp_q.delete();
        return;
      end
      bus.respack = !(beats == stall_beat && st > 0);
      @(negedge clk);
      if (k == 0) chk("reqack_one_cycle", bus.reqack, 0);
      else if (overlap) chk("no_ack_busy", bus.reqack, 0);
      if (bus.respcyc) begin
        if (first < 0) begin
          first = cyc;
          d0    = bus.resp;
        end
        if (bus.respack) begin
          beats++;
          last = cyc;
        end else begin
          st--;
        end
      end
    end
    bus.respack = 1'b1;
    chk("read_beats", beats, 8);
    chk("first_beat_cyc", 64'(first), 64'(t + 2 + lat));
    chk("beat_span", 64'(last - first), 64'(7 + stall_n));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("respcyc_drop", bus.respcyc, 0);
    if (overlap) chk("no_ack_idle_cycle", bus.reqack, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] d;
    bit          got;
    int          t0;
    int          b;
    int          first;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.reqcyc = 1'b0;  bus.req = '0;  bus.reqtag = '0;  bus.respack = 1'b0;
    bus0.reqcyc = 1'b0; bus0.req = '0; bus0.reqtag = '0; bus0.respack = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_reqack", bus.reqack, 0);
    chk("rst_respcyc", bus.respcyc, 0);
    chk("rst_resp", bus.resp, 0);
    chk("rst_resptag", bus.resptag, 0);
    chk("rst0_respcyc", bus0.respcyc, 0);
    chk("rst0_reqack", bus0.reqack, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // preload line 0x1000 with 1..8 through the write path, then plain reads
    do_write(64'h1000, {DIR_WRITE, TYPE_MEMORY, 8'h01}, 64'h1);
    chk("model_pin_1038", mem_m[64'h1038], 64'h8);
    do_read(64'h1000, {DIR_READ, TYPE_MEMORY, 8'h22}, 4, -1, 0, -1, 1'b0, d);
    chk("t1_first_data", d, 64'h1);
    do_read(64'h1013, {DIR_READ, 4'h2, 8'h33}, 4, -1, 0, -1, 1'b0, d);
    chk("t2_first_data", d, 64'h1);
    do_read(64'h1000, {DIR_READ, TYPE_MEMORY, 8'h3C}, 4, 2, 3, -1, 1'b0, d);

    do_write(64'h2000, {DIR_WRITE, TYPE_MEMORY, 8'h44}, 64'hA0);
    do_read(64'h2000, {DIR_READ, TYPE_MEMORY, 8'h45}, 4, -1, 0, -1, 1'b0, d);
    chk("t4_first_data", d, 64'hA0);

    // an out-of-range write must not alias onto line 0
    do_write(64'h0, {DIR_WRITE, TYPE_MEMORY, 8'h50}, 64'h10);
    do_write(MEM_B, {DIR_WRITE, TYPE_MEMORY, 8'h51}, 64'h55);
    chk("model_pin_0", mem_m[64'h0], 64'h10);
    do_read(64'h0, {DIR_READ, TYPE_MEMORY, 8'h52}, 4, -1, 0, -1, 1'b0, d);
    chk("t4b_first_data", d, 64'h10);

    // reset while beat 4 is on the bus
    do_read(64'h1000, {DIR_READ, TYPE_MEMORY, 8'h60}, 4, -1, 0, 4, 1'b0, d);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_respcyc", bus.respcyc, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_respcyc", bus.respcyc, 0);
      @(posedge clk);
      #1;
    end
    do_read(64'h1000, {DIR_READ, TYPE_MEMORY, 8'h61}, 4, -1, 0, -1, 1'b0, d);
    chk("t5_first_data", d, 64'h1);

    // out-of-range read with a second request held through the transfer
    do_read(MEM_B, {DIR_READ, TYPE_MEMORY, 8'h70}, 4, -1, 0, -1, 1'b1, d);
    chk("t6_first_data", d, 64'h0);
    do_read(MEM_B, {DIR_READ, TYPE_MEMORY, 8'h70}, 4, -1, 0, -1, 1'b0, d);
    chk("t6b_first_data", d, 64'h0);
    bus.reqcyc = 1'b0;

    // LAT=0 instance, address equal to its 4096-byte store size
    bus0.reqcyc  = 1'b1;
    bus0.req     = 64'h1000;
    bus0.reqtag  = {DIR_READ, TYPE_MEMORY, 8'h77};
    bus0.respack = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus0.reqack) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("lat0_reqack_seen", got, 1);
    t0 = cyc - 1;
    @(posedge clk);
    #1;
    bus0.reqcyc = 1'b0;
    b     = 0;
    first = -1;
    for (int k = 0; k < 40 && b < 8; k++) begin
      @(negedge clk);
      if (bus0.respcyc) begin
        if (first < 0) first = cyc;
        chk("lat0_data", bus0.resp, 64'h0);
        chk("lat0_tag", bus0.resptag, {DIR_READ, TYPE_MEMORY, 8'h77});
        b++;
      end
      @(posedge clk);
      #1;
    end
    chk("lat0_beats", b, 8);
    chk("lat0_first_cyc", 64'(first), 64'(t0 + 2));
    @(negedge clk);
    chk("lat0_drop", bus0.respcyc, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
